pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer for the CPU fetch stage; replaces the plain PC register.
//  Holds the PC and selects the next PC each cycle: increment, branch/jump redirect, trap vector, stall, halt.
//  Optional return-address stack (RAS) serves call/return. Feeds instruction-memory address and fetch valid.
// PARAMETERS
//  ADDR_W    16       PC width in bits
//  STEP      1        increment per instruction; power of two, at least 1
//  RESET_VEC '0       PC loaded on reset
//  TRAP_VEC  'hFFF0   PC loaded on trap (truncated to ADDR_W)
//  RAS_DEPTH 4        RAS entries; power of two, at least 2 (used only with PC_RAS_EN)
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-low reset
//  stall_i        in   1       hold PC this cycle (pipeline back-pressure)
//  branch_i       in   1       redirect to branch_target_i (jump or taken branch)
//  call_i         in   1       call: redirect to branch_target_i, push return address (RAS)
//  ret_i          in   1       return: redirect to popped address (RAS) or branch_target_i
//  branch_target_i in  ADDR_W  redirect target
//  trap_i         in   1       redirect to TRAP_VEC
//  halt_i         in   1       enter HALT
//  resume_i       in   1       leave HALT
//  pc_o           out  ADDR_W  current PC, registered
//  pc_plus_o      out  ADDR_W  pc_o+STEP, combinational, modulo 2^ADDR_W
//  fetch_valid_o  out  1       pc_o is a valid fetch address this cycle
//  halted_o       out  1       FSM is in HALT
//  ras_err_o      out  1       one-cycle pulse on RAS overflow or underflow
// BEHAVIOUR
//  Reset values (async on reset low): pc_o=RESET_VEC, fetch_valid_o=0, halted_o=0, ras_err_o=0,
//    RAS empty, state BOOT. Reset mid-operation has the same effect as reset at power-up.
//  FSM states:
//    BOOT: exactly one cycle after reset release, fetch_valid_o=0, pc_o unchanged; -> RUN.
//    RUN: fetch_valid_o=1 unless stall_i is high in that cycle (combinational).
//    HALT: pc_o frozen; fetch_valid_o=0; halted_o=1.
//      resume_i -> RUN, pc_o unchanged. trap_i -> RUN with pc_o=TRAP_VEC. Redirects ignored.
//  RUN next-PC priority, highest first; each step is one cycle latency, registered:
//    1 trap_i              -> TRAP_VEC
//    2 ret_i               -> pop address (RAS) or branch_target_i; a simultaneous call_i is ignored
//    3 call_i              -> branch_target_i; push pc_plus_o (RAS)
//    4 branch_i            -> branch_target_i
//    5 halt_i              -> HALT; pc_o holds
//    6 stall_i             -> hold
//    7 else                -> pc_plus_o
//  Redirects (priorities 1-4) win over stall_i: a redirect is never lost during a stall.
//  Redirect targets: the low log2(STEP) bits are forced to 0.
//  Increment wraps modulo 2^ADDR_W silently (all-ones plus STEP gives 0 for STEP=1).
// CONFIGURATION
//  PC_RAS_EN defined:
//    circular RAS of RAS_DEPTH entries; call pushes; ret pops to pc_o.
//    push when full overwrites the oldest entry and pulses ras_err_o.
//    pop when empty: target RESET_VEC, pulses ras_err_o.
//    ret with call in the same cycle: pop only.
//    RAS cleared on reset only; trap does not clear it.
//  PC_RAS_EN undefined:
//    no storage; call_i acts as branch_i; ret_i redirects to branch_target_i.
//    ras_err_o tied 0.
// STRUCTURE
//  Package pc_pkg: typedef enum pc_state_t {BOOT, RUN, HALT}; localparam for default TRAP_VEC.
//  Sub-module pc_ras (PC_RAS_EN only):
//    ports: clk, reset, push, pop, push_addr, pop_addr, overflow, underflow.
//    internals: head pointer and count.
//  Top level: FSM plus next-PC priority mux.
// TESTING
//  T1: reset low mid-RUN at pc=0x0042 -> pc_o=RESET_VEC immediately;
//      after release one BOOT cycle with fetch_valid_o=0, then pc_o 0,1,2.
//  T2: pc=0xFFFF, STEP=1, no controls -> next pc_o=0x0000; pc_plus_o=0x0001.
//  T3: stall_i=1 for 3 cycles at pc=0x0010 -> pc_o holds, fetch_valid_o=0;
//      stall_i=1 and branch_i=1 (target 0x0200) together -> next pc_o=0x0200.
//  T4: trap_i, branch_i and halt_i together at pc=0x0005 -> pc_o=0xFFF0 and state RUN;
//      in HALT, trap_i -> pc_o=0xFFF0 and halted_o=0.
//  T5 (PC_RAS_EN, RAS_DEPTH=4):
//      5 calls from pc 0x10,0x20,0x30,0x40,0x50 -> ras_err_o pulses on the 5th call;
//      4 rets -> pc_o 0x51,0x41,0x31,0x21; 5th ret -> pc_o=RESET_VEC and ras_err_o pulse.
//  T6: halt_i at pc=0x0008 -> halted_o=1 and pc_o=0x0008 for 10 cycles;
//      branch_i ignored; resume_i -> RUN, next pc_o=0x0009.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared state encodings and defaults for the program-counter sequencer.
package pc_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_t;
    localparam logic [1:0] ST_BOOT = BOOT;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_HALT = HALT;
    localparam logic [31:0] DEF_TRAP_VEC = 32'hFFF0;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-control inputs and PC outputs of the sequencer.
interface pc_sequencer_if #(parameter int ADDR_W = 16);
    logic              stall_i, branch_i, call_i, ret_i, trap_i, halt_i, resume_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic [ADDR_W-1:0] pc_o, pc_plus_o;
    logic              fetch_valid_o, halted_o, ras_err_o;
    modport master (
        output stall_i, branch_i, call_i, ret_i, trap_i, halt_i, resume_i, branch_target_i,
        input  pc_o, pc_plus_o, fetch_valid_o, halted_o, ras_err_o
    );
    modport slave (
        input  stall_i, branch_i, call_i, ret_i, trap_i, halt_i, resume_i, branch_target_i,
        output pc_o, pc_plus_o, fetch_valid_o, halted_o, ras_err_o
    );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] pop_addr,
    output logic              overflow,
    output logic              underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] H1 = PW'(1);
    localparam logic [PW:0]   C1 = (PW+1)'(1);
    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic              full, empty;
    assign full      = cnt_q == (PW+1)'(DEPTH);
    assign empty     = cnt_q == '0;
    assign pop_addr  = mem_q[head_q - H1];
    assign overflow  = push && !pop && full;
    assign underflow = pop && empty;
    always_comb begin
        head_d = head_q;
        cnt_d  = cnt_q;
        if (pop) begin
            head_d = empty ? head_q : head_q - H1;
            cnt_d  = empty ? cnt_q : cnt_q - C1;
        end else if (push) begin
            head_d = head_q + H1;
            cnt_d  = full ? cnt_q : cnt_q + C1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            cnt_q  <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !pop) mem_q[head_q] <= push_addr;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with BOOT/RUN/HALT FSM and prioritised next-PC mux.
// Define PC_RAS_EN to add a return-address stack for call/ret.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                 ADDR_W    = 16,
    parameter int                 STEP      = 1,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter logic [ADDR_W-1:0]  TRAP_VEC  = ADDR_W'(DEF_TRAP_VEC),
    parameter int                 RAS_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam logic [ADDR_W-1:0] AMASK  = ~ADDR_W'(STEP - 1);
    localparam logic [ADDR_W-1:0] TRAP_A = TRAP_VEC & AMASK;
    logic [1:0]        st_q, st_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt, ret_tgt;
    logic              run;
    assign run = st_q == ST_RUN;
    assign tgt = bus.branch_target_i & AMASK;
`ifdef PC_RAS_EN
    logic              push, pop, ovf, unf, err_q, err_d;
    logic [ADDR_W-1:0] pop_addr;
    // a trap suppresses stack traffic; ret wins over a simultaneous call
    assign push = run && !bus.trap_i && !bus.ret_i && bus.call_i;
    assign pop  = run && !bus.trap_i && bus.ret_i;
    pc_ras #(.ADDR_W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_addr (bus.pc_plus_o),
        .pop_addr  (pop_addr),
        .overflow  (ovf),
        .underflow (unf)
    );
    assign ret_tgt = unf ? RESET_VEC : pop_addr & AMASK;
    assign err_d   = ovf || unf;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign bus.ras_err_o = err_q;
`else
    assign ret_tgt       = tgt;
    assign bus.ras_err_o = 1'b0;
`endif
    always_comb begin
        st_d = st_q;
        pc_d = pc_q;
        if (st_q == ST_BOOT) begin
            st_d = ST_RUN;
        end else if (st_q == ST_HALT) begin
            if (bus.trap_i) begin
                st_d = ST_RUN;
                pc_d = TRAP_A;
            end else if (bus.resume_i) begin
                st_d = ST_RUN;
            end
        end else if (bus.trap_i) begin
            pc_d = TRAP_A;
        end else if (bus.ret_i) begin
            pc_d = ret_tgt;
        end else if (bus.call_i || bus.branch_i) begin
            pc_d = tgt;
        end else if (bus.halt_i) begin
            st_d = ST_HALT;
        end else if (!bus.stall_i) begin
            pc_d = bus.pc_plus_o;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q <= ST_BOOT;
            pc_q <= RESET_VEC;
        end else begin
            st_q <= st_d;
            pc_q <= pc_d;
        end
    end
    assign bus.pc_o          = pc_q;
    assign bus.pc_plus_o     = pc_q + ADDR_W'(STEP);
    assign bus.fetch_valid_o = run && !bus.stall_i;
    assign bus.halted_o      = st_q == ST_HALT;
endmodule
